jpeg_block_ingest: RTL and testbench

- Parametrised multi-channel pixel-to-8x8-block front end for the JPEG encoder.
- Sits between the colour converter (Y/Cb/Cr samples, s10) and the per-channel DCT stages.
- Accepts one raster-ordered pixel per cycle for NUM_CH channels with a valid/ready handshake. Double-buffers whole 8x8 blocks, then emits them one 8-pixel row per transfer, channel-major.
- Replaces the hand-driven input/dct enable strobes with a flow-controlled interface. Adds luma-only mode and back-pressure.

---
 rtl/jpeg_enc_pkg.sv | 26 ++
 rtl/jpeg_block_bank.sv | 50 +++++
 rtl/jpeg_block_ingest.sv | 149 ++++++++++++++
 tb/tb_jpeg_block_ingest.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_enc_pkg.sv
// Shared constants, read-FSM state type and raster-index helper for the JPEG encoder
// block ingest path.
package jpeg_enc_pkg;

  localparam int unsigned PixWDefault = 10;
  localparam int unsigned BlkDim      = 8;
  localparam int unsigned BlkPix      = 64;

  typedef enum logic {
    StIdle,
    StSend
  } rd_state_e;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
  } raster_pos_t;

  function automatic raster_pos_t raster_split(input logic [5:0] idx);
    raster_pos_t pos;
    pos.row = idx[5:3];
    pos.col = idx[2:0];
    return pos;
  endfunction

endpackage

// File: rtl/jpeg_block_bank.sv
// One 8x8 sample bank for all channels plus the luma-only mode bit latched at pixel 0.
// Writes a whole pixel (every channel) at once; reads one row of one channel.
module jpeg_block_bank
  import jpeg_enc_pkg::*;
#(
  parameter int unsigned PIX_W  = PixWDefault,
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CH_W   = 2
) (
  input  logic                    clk_i,
  input  logic                    wr_en_i,
  input  logic [5:0]              wr_idx_i,
  input  logic [NUM_CH*PIX_W-1:0] wr_data_i,
  input  logic                    wr_mode_i,
  input  logic [CH_W-1:0]         rd_ch_i,
  input  logic [2:0]              rd_row_i,
  output logic [8*PIX_W-1:0]      rd_data_o,
  output logic                    rd_mode_o
);

  logic [NUM_CH*PIX_W-1:0] mem_q [BlkDim][BlkDim];
  logic                    mode_q;
  raster_pos_t             wr_pos;

  assign wr_pos    = raster_split(wr_idx_i);
  assign rd_mode_o = mode_q;

  // Sample storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_pos.row][wr_pos.col] <= wr_data_i;
      if (wr_idx_i == '0) begin
        mode_q <= wr_mode_i;
      end
    end
  end

  // Constant-index channel mux keeps every part-select in range.
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < BlkDim; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (rd_ch_i == CH_W'(c)) begin
          rd_data_o[k*PIX_W +: PIX_W] = mem_q[rd_row_i][k[2:0]][c*PIX_W +: PIX_W];
        end
      end
    end
  end

endmodule

// File: rtl/jpeg_block_ingest.sv
// Raster pixel stream to 8x8 block rows, double-buffered, channel-major output with
// valid/ready flow control on both sides and an optional luma-only mode per block.
module jpeg_block_ingest
  import jpeg_enc_pkg::*;
#(
  parameter int unsigned PIX_W  = PixWDefault,
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CH_W   = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    luma_only,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [NUM_CH*PIX_W-1:0] pix_data,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic [CH_W-1:0]         blk_ch,
  output logic [2:0]              blk_row,
  output logic [8*PIX_W-1:0]      blk_data,
  output logic                    blk_last,
  output logic [15:0]             blk_count
);

  rd_state_e       state_q, state_d;
  logic [1:0]      full_q, full_d;
  logic            wr_bank_q, wr_bank_d;
  logic [5:0]      wr_idx_q, wr_idx_d;
  logic            rd_bank_q, rd_bank_d;
  logic [CH_W-1:0] rd_ch_q, rd_ch_d;
  logic [2:0]      rd_row_q, rd_row_d;
  logic [15:0]     blk_count_q, blk_count_d;

  logic               accept;
  logic               row_last;
  logic [CH_W-1:0]    last_ch;
  logic [1:0]         bank_we;
  logic [1:0]         bank_mode;
  logic [8*PIX_W-1:0] bank_rdata [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    jpeg_block_bank #(
      .PIX_W  (PIX_W),
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
    ) u_bank (
      .clk_i     (clock),
      .wr_en_i   (bank_we[b]),
      .wr_idx_i  (wr_idx_q),
      .wr_data_i (pix_data),
      .wr_mode_i (luma_only),
      .rd_ch_i   (rd_ch_q),
      .rd_row_i  (rd_row_q),
      .rd_data_o (bank_rdata[b]),
      .rd_mode_o (bank_mode[b])
    );
  end

  // pix_ready depends only on registered flags, never on blk_ready.
  assign pix_ready = !full_q[wr_bank_q];
  assign accept    = pix_valid && pix_ready;
  assign last_ch   = bank_mode[rd_bank_q] ? '0 : CH_W'(NUM_CH - 1);
  assign row_last  = (state_q == StSend) && (rd_row_q == 3'd7) && (rd_ch_q == last_ch);

  assign blk_valid = (state_q == StSend);
  assign blk_ch    = rd_ch_q;
  assign blk_row   = rd_row_q;
  assign blk_last  = row_last;
  assign blk_data  = bank_rdata[rd_bank_q];
  assign blk_count = blk_count_q;

  always_comb begin
    bank_we            = '0;
    bank_we[wr_bank_q] = accept;
  end

  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    rd_bank_d   = rd_bank_q;
    rd_ch_d     = rd_ch_q;
    rd_row_d    = rd_row_q;
    blk_count_d = blk_count_q;

    if (accept) begin
      if (wr_idx_q == 6'(BlkPix - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + 6'd1;
      end
    end

    // Write and read always target different banks, so set and clear never collide.
    case (state_q)
      StIdle: begin
        if (full_q[rd_bank_q]) begin
          state_d  = StSend;
          rd_ch_d  = '0;
          rd_row_d = '0;
        end
      end
      StSend: begin
        if (blk_ready) begin
          if (row_last) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            blk_count_d       = blk_count_q + 16'd1;
            state_d           = StIdle;
            rd_ch_d           = '0;
            rd_row_d          = '0;
          end else if (rd_row_q == 3'd7) begin
            rd_row_d = '0;
            rd_ch_d  = rd_ch_q + CH_W'(1);
          end else begin
            rd_row_d = rd_row_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_ch_q     <= '0;
      rd_row_q    <= '0;
      blk_count_q <= '0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_bank_q   <= rd_bank_d;
      rd_ch_q     <= rd_ch_d;
      rd_row_q    <= rd_row_d;
      blk_count_q <= blk_count_d;
    end
  end

endmodule

// File: tb/tb_jpeg_block_ingest.sv
// Bench for jpeg_block_ingest: random stimulus against a block-queue reference model,
// plus directed scenarios for ordering, back-pressure, luma-only mode and reset.
module tb_jpeg_block_ingest;

  localparam int PW = 10;
  localparam int NC = 3;
  localparam int CW = 2;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             luma_only = 1'b0;
  logic             pix_valid = 1'b0;
  logic             pix_ready;
  logic [NC*PW-1:0] pix_data = '0;
  logic             blk_valid;
  logic             blk_ready = 1'b1;
  logic [CW-1:0]    blk_ch;
  logic [2:0]       blk_row;
  logic [8*PW-1:0]  blk_data;
  logic             blk_last;
  logic [15:0]      blk_count;

  always #5 clock = ~clock;

  jpeg_block_ingest #(
    .PIX_W  (PW),
    .NUM_CH (NC),
    .CH_W   (CW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .luma_only (luma_only),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_ch    (blk_ch),
    .blk_row   (blk_row),
    .blk_data  (blk_data),
    .blk_last  (blk_last),
    .blk_count (blk_count)
  );

  typedef struct {
    logic [CW-1:0]   ch;
    logic [2:0]      row;
    logic [8*PW-1:0] data;
    logic            last;
  } row_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: completed input blocks expand into a queue of expected rows.
  row_t             exp_q[$];
  logic [NC*PW-1:0] cur_blk [64];
  logic             cur_mode;
  int               acc_cnt = 0;
  int               pending = 0;
  int               idle_left = 0;
  int               rows_out = 0;
  int               lasts_out = 0;
  int               stall_cnt = 0;
  logic [15:0]      model_count = '0;
  logic [8*PW-1:0]  cap_data;
  bit               hold_v = 0;
  logic [CW-1:0]    hold_ch;
  logic [2:0]       hold_row;
  logic [8*PW-1:0]  hold_data;
  logic             hold_last;
  int               rdy_mode = 0;

  always @(negedge clock) begin
    row_t e;
    bit   exp_v;
    bit   last_x;
    int   pend_before;
    int   lastc;
    if (!reset_n) begin
      exp_q.delete();
      acc_cnt     = 0;
      pending     = 0;
      idle_left   = 0;
      model_count = '0;
      hold_v      = 0;
    end else begin
      exp_v = (pending > 0) && (idle_left == 0);
      if (pending > 0 && idle_left > 0) idle_left = 0;
      n_vec++;
      if (blk_valid !== exp_v) begin
        n_err++;
        $display("FAIL blk_valid @%0t: got %b required %b", $time, blk_valid, exp_v);
      end
      n_vec++;
      if (pix_ready !== (pending < 2)) begin
        n_err++;
        $display("FAIL pix_ready @%0t: got %b required %b", $time, pix_ready, pending < 2);
      end
      n_vec++;
      if (blk_count !== model_count) begin
        n_err++;
        $display("FAIL blk_count @%0t: got %0d required %0d", $time, blk_count, model_count);
      end
      if (hold_v) begin
        n_vec++;
        if ({blk_ch, blk_row, blk_last, blk_data} !== {hold_ch, hold_row, hold_last, hold_data})
        begin
          n_err++;
          $display("FAIL hold_stable @%0t: got ch=%0d row=%0d data=%h required ch=%0d row=%0d data=%h",
                   $time, blk_ch, blk_row, blk_data, hold_ch, hold_row, hold_data);
        end
      end
      if (blk_valid === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_row @%0t: got ch=%0d row=%0d required no row", $time, blk_ch,
                   blk_row);
        end else if ({blk_ch, blk_row, blk_last, blk_data} !==
                     {exp_q[0].ch, exp_q[0].row, exp_q[0].last, exp_q[0].data}) begin
          n_err++;
          $display("FAIL row @%0t: got ch=%0d row=%0d last=%b data=%h required ch=%0d row=%0d last=%b data=%h",
                   $time, blk_ch, blk_row, blk_last, blk_data, exp_q[0].ch, exp_q[0].row,
                   exp_q[0].last, exp_q[0].data);
        end
      end
      if (pix_valid && !pix_ready) stall_cnt++;

      pend_before = pending;
      last_x      = 0;
      hold_v      = blk_valid && !blk_ready;
      hold_ch     = blk_ch;
      hold_row    = blk_row;
      hold_data   = blk_data;
      hold_last   = blk_last;
      if (blk_valid && blk_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cap_data = blk_data;
        rows_out++;
        if (e.last) begin
          lasts_out++;
          pending--;
          model_count++;
          last_x = 1;
        end
      end
      if (pix_valid && pix_ready) begin
        if (acc_cnt == 0) cur_mode = luma_only;
        cur_blk[acc_cnt] = pix_data;
        acc_cnt++;
        if (acc_cnt == 64) begin
          lastc = cur_mode ? 0 : NC - 1;
          for (int c = 0; c <= lastc; c++) begin
            for (int r = 0; r < 8; r++) begin
              e.ch  = CW'(c);
              e.row = 3'(r);
              for (int k = 0; k < 8; k++) e.data[k*PW +: PW] = cur_blk[8*r+k][c*PW +: PW];
              e.last = (c == lastc) && (r == 7);
              exp_q.push_back(e);
            end
          end
          pending++;
          acc_cnt = 0;
        end
      end
      // One IDLE cycle precedes every block's first row.
      if (pending > 0 && (last_x || pend_before == 0)) idle_left = 1;
    end
  end

  function automatic logic [NC*PW-1:0] pat_single(input int i);
    logic [NC*PW-1:0] v;
    for (int c = 0; c < NC; c++) v[c*PW +: PW] = PW'(c * 100 + i - 512);
    return v;
  endfunction

  task automatic push_pix(input logic [NC*PW-1:0] d, input logic mode, input int bubble_pct);
    int t;
    while (bubble_pct > 0 && int'($urandom_range(99)) < bubble_pct) begin
      pix_valid = 1'b0;
      @(posedge clock);
      #1;
    end
    pix_valid = 1'b1;
    pix_data  = d;
    luma_only = mode;
    t = 0;
    forever begin
      @(negedge clock);
      if (pix_ready === 1'b1) break;
      t++;
      if (t > 2000) begin
        n_vec++;
        n_err++;
        $display("FAIL push_timeout: pix_ready got %b required 1 within 2000 cycles", pix_ready);
        pix_valid = 1'b0;
        return;
      end
    end
    @(posedge clock);
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((pending != 0 || exp_q.size() != 0) && t < 5000) begin
      @(posedge clock);
      t++;
    end
    n_vec++;
    if (pending != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d pending blocks required 0", pending);
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    n_vec++;
    if (pix_ready !== 1'b1) begin n_err++; $display("FAIL reset_pix_ready: got %b required 1", pix_ready); end
    n_vec++;
    if (blk_valid !== 1'b0) begin n_err++; $display("FAIL reset_blk_valid: got %b required 0", blk_valid); end
    n_vec++;
    if (blk_ch !== '0) begin n_err++; $display("FAIL reset_blk_ch: got %0d required 0", blk_ch); end
    n_vec++;
    if (blk_row !== 3'd0) begin n_err++; $display("FAIL reset_blk_row: got %0d required 0", blk_row); end
    n_vec++;
    if (blk_last !== 1'b0) begin n_err++; $display("FAIL reset_blk_last: got %b required 0", blk_last); end
    n_vec++;
    if (blk_count !== 16'd0) begin n_err++; $display("FAIL reset_blk_count: got %0d required 0", blk_count); end
  endtask

  task automatic test_single_block();
    int r0, l0;
    logic [8*PW-1:0] want;
    rdy_mode = 0;
    r0 = rows_out;
    l0 = lasts_out;
    for (int i = 0; i < 64; i++) push_pix(pat_single(i), 1'b0, 0);
    wait_drain();
    for (int k = 0; k < 8; k++) want[k*PW +: PW] = PW'(200 + 56 + k - 512);
    n_vec++;
    if (cap_data !== want) begin n_err++; $display("FAIL single_ch2_row7: got %h required %h", cap_data, want); end
    n_vec++;
    if (rows_out - r0 != 24) begin n_err++; $display("FAIL single_rows: got %0d required 24", rows_out - r0); end
    n_vec++;
    if (lasts_out - l0 != 1) begin n_err++; $display("FAIL single_lasts: got %0d required 1", lasts_out - l0); end
    n_vec++;
    if (blk_count !== 16'd1) begin n_err++; $display("FAIL single_count: got %0d required 1", blk_count); end
  endtask

  task automatic test_stream();
    int s0, r0;
    rdy_mode = 0;
    s0 = stall_cnt;
    r0 = rows_out;
    for (int i = 0; i < 256; i++) push_pix(NC*PW'($urandom), 1'b0, 0);
    wait_drain();
    n_vec++;
    if (stall_cnt != s0) begin n_err++; $display("FAIL stream_stalls: got %0d required 0", stall_cnt - s0); end
    n_vec++;
    if (rows_out - r0 != 96) begin n_err++; $display("FAIL stream_rows: got %0d required 96", rows_out - r0); end
    n_vec++;
    if (blk_count !== 16'd5) begin n_err++; $display("FAIL stream_count: got %0d required 5", blk_count); end
  endtask

  task automatic test_backpressure();
    int s0, r0, t;
    rdy_mode = 1;
    repeat (2) @(posedge clock);
    #1;
    s0 = stall_cnt;
    r0 = rows_out;
    for (int i = 0; i < 128; i++) push_pix(NC*PW'($urandom), 1'b0, 0);
    n_vec++;
    if (stall_cnt != s0) begin n_err++; $display("FAIL bp_early_stall: got %0d required 0", stall_cnt - s0); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_vec++;
      if (pix_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_low: got %b required 0", pix_ready); end
    end
    rdy_mode = 0;
    t = 0;
    while (pix_ready !== 1'b1 && t < 200) begin
      @(posedge clock);
      #1;
      t++;
    end
    n_vec++;
    if (pix_ready !== 1'b1) begin n_err++; $display("FAIL bp_resume: got %b required 1", pix_ready); end
    n_vec++;
    if (rows_out - r0 != 24) begin n_err++; $display("FAIL bp_rows_at_resume: got %0d required 24", rows_out - r0); end
    wait_drain();
    n_vec++;
    if (blk_count !== 16'd7) begin n_err++; $display("FAIL bp_count: got %0d required 7", blk_count); end
  endtask

  task automatic test_luma_only();
    int r0, l0;
    rdy_mode = 0;
    r0 = rows_out;
    l0 = lasts_out;
    // Mode is only meaningful on each block's first pixel.
    for (int i = 0; i < 64; i++) push_pix(NC*PW'($urandom), i == 0, 0);
    for (int i = 0; i < 64; i++) push_pix(NC*PW'($urandom), i != 0, 0);
    wait_drain();
    n_vec++;
    if (rows_out - r0 != 32) begin n_err++; $display("FAIL luma_rows: got %0d required 32", rows_out - r0); end
    n_vec++;
    if (lasts_out - l0 != 2) begin n_err++; $display("FAIL luma_lasts: got %0d required 2", lasts_out - l0); end
    n_vec++;
    if (blk_count !== 16'd9) begin n_err++; $display("FAIL luma_count: got %0d required 9", blk_count); end
  endtask

  task automatic test_random();
    int r0, want_rows;
    logic m;
    rdy_mode = 2;
    r0 = rows_out;
    want_rows = 0;
    for (int b = 0; b < 6; b++) begin
      m = 1'($urandom_range(1));
      want_rows += m ? 8 : 24;
      for (int i = 0; i < 64; i++) push_pix(NC*PW'($urandom), (i == 0) ? m : 1'($urandom_range(1)), 50);
    end
    wait_drain();
    rdy_mode = 0;
    n_vec++;
    if (rows_out - r0 != want_rows) begin
      n_err++;
      $display("FAIL random_rows: got %0d required %0d", rows_out - r0, want_rows);
    end
    n_vec++;
    if (blk_count !== 16'd15) begin n_err++; $display("FAIL random_count: got %0d required 15", blk_count); end
  endtask

  task automatic test_mid_reset();
    int r0;
    rdy_mode = 0;
    for (int i = 0; i < 40; i++) push_pix(NC*PW'($urandom), 1'b0, 0);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    r0 = rows_out;
    repeat (100) @(posedge clock);
    #1;
    n_vec++;
    if (rows_out != r0) begin n_err++; $display("FAIL mid_reset_rows: got %0d required 0", rows_out - r0); end
    n_vec++;
    if (blk_count !== 16'd0) begin n_err++; $display("FAIL mid_reset_count: got %0d required 0", blk_count); end
    for (int i = 0; i < 64; i++) push_pix(pat_single(i), 1'b0, 0);
    wait_drain();
    n_vec++;
    if (rows_out - r0 != 24) begin n_err++; $display("FAIL post_reset_rows: got %0d required 24", rows_out - r0); end
    n_vec++;
    if (blk_count !== 16'd1) begin n_err++; $display("FAIL post_reset_count: got %0d required 1", blk_count); end
  endtask

  initial begin
    fork
      forever begin
        @(posedge clock);
        #1;
        case (rdy_mode)
          0: blk_ready = 1'b1;
          1: blk_ready = 1'b0;
          default: blk_ready = 1'($urandom_range(1));
        endcase
      end
    join_none
    test_reset();
    test_single_block();
    test_stream();
    test_backpressure();
    test_luma_only();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
